// File: rtl/dmem_banked_pkg.sv
// rtl/dmem_banked_pkg.sv - shared types and lane-rotation helpers for dmem_banked
// Purpose: init FSM state enum and byte-lane rotate/un-rotate functions.
// The functions work on a MAX_LANES-wide vector and take the active lane
// count as an argument, so one package serves any LANES up to MAX_LANES.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DONE} init_state_e;

  localparam int MAX_LANES = 16;
  typedef logic [8*MAX_LANES-1:0] lane_vec_t;

  // Byte j of d moves to lane (j+off) mod lanes (store path).
  function automatic lane_vec_t lane_rotate(input lane_vec_t d, input int off, input int lanes);
    lane_vec_t r;
    r = '0;
    for (int j = 0; j < MAX_LANES; j++)
      if (j < lanes) r[8*((j+off)%lanes) +: 8] = d[8*j +: 8];
    return r;
  endfunction

  // Byte j of the result comes from lane (j+off) mod lanes (load path).
  function automatic lane_vec_t lane_unrotate(input lane_vec_t d, input int off, input int lanes);
    lane_vec_t r;
    r = '0;
    for (int j = 0; j < MAX_LANES; j++)
      if (j < lanes) r[8*j +: 8] = d[8*((j+off)%lanes) +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dmem_banked_if.sv
// rtl/dmem_banked_if.sv - request/response and debug-init bus of dmem_banked
// Purpose: groups the access handshake, the registered response and the
// init-burst handshake. master = client side, slave = memory side.
// Signals: req_valid/req_ready/req_addr/req_we/req_wdata, rsp_valid/rsp_rdata/
// rsp_err, init_start/init_base/init_count/init_valid/init_ready/init_data/
// init_busy/init_done.
interface dmem_banked_if #(parameter int LANES = 4);
  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_addr;
  logic [LANES-1:0]     req_we;
  logic [8*LANES-1:0]   req_wdata;
  logic                 rsp_valid;
  logic [8*LANES-1:0]   rsp_rdata;
  logic                 rsp_err;
  logic                 init_start;
  logic [31:0]          init_base;
  logic [15:0]          init_count;
  logic                 init_valid;
  logic                 init_ready;
  logic [16*LANES-1:0]  init_data;
  logic                 init_busy;
  logic                 init_done;

  modport master (
    output req_valid, req_addr, req_we, req_wdata,
           init_start, init_base, init_count, init_valid, init_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           init_ready, init_busy, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
           init_start, init_base, init_count, init_valid, init_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           init_ready, init_busy, init_done
  );
endinterface

// File: rtl/dmem_banked_bank.sv
// rtl/dmem_banked_bank.sv - one byte-wide lane bank of dmem_banked
// Purpose: DEPTH_WORDS x 8 storage with two write ports.
// Ports: clk; port A a_addr/a_we/a_wdata/a_rdata (read-first, registered
// read every cycle); port B b_addr/b_we/b_wdata (write-only).
// Contents are not reset.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] a_addr,
  input  logic                           a_we,
  input  logic [7:0]                     a_wdata,
  output logic [7:0]                     a_rdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] b_addr,
  input  logic                           b_we,
  input  logic [7:0]                     b_wdata
);

  logic [7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    a_rdata <= mem[a_addr];
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

endmodule

// File: rtl/dmem_banked.sv
// rtl/dmem_banked.sv - byte-lane banked data memory with init engine
// Purpose: LANES rotated byte banks so any byte address is one access;
// range check, registered valid-qualified response, debug-init burst FSM.
// Ports: clk, rst (sync, active-high), bus (dmem_banked_if.slave).
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  dmem_banked_if.slave  bus
);

  localparam int MEM_BYTES = LANES * DEPTH_WORDS;
  localparam int OFFW      = $clog2(LANES);
  localparam int WAW       = $clog2(DEPTH_WORDS);
  localparam int AW        = OFFW + WAW;

  init_state_e      state;
  logic [WAW-1:0]   ptr;
  logic [15:0]      rem;
  logic             init_busy_q, init_done_q, init_ready_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [OFFW-1:0]  rsp_off;

  logic [OFFW-1:0]  off;
  logic [WAW-1:0]   word;
  logic             err, acc, fill, init_fire, high_en;
  lane_vec_t        we_mask, we_mask_rot, wdata_rot, rd_unrot;
  logic [8*LANES-1:0] bank_q;

  assign off       = bus.req_addr[OFFW-1:0];
  assign word      = bus.req_addr[AW-1:OFFW];
  // 33-bit sum so addresses near 2^32 cannot wrap past the check.
  assign err       = ({1'b0, bus.req_addr} + 33'(LANES - 1)) >= 33'(MEM_BYTES);
  assign bus.req_ready = (state == IDLE);
  assign acc       = bus.req_valid && bus.req_ready;
  assign fill      = (state == FILL);
  assign init_fire = fill && bus.init_valid;
  assign high_en   = rem > 16'd1;

  always_comb begin
    we_mask = '0;
    for (int j = 0; j < LANES; j++) we_mask[8*j +: 8] = {8{bus.req_we[j]}};
  end

  assign wdata_rot   = lane_rotate(lane_vec_t'(bus.req_wdata), int'(off), LANES);
  assign we_mask_rot = lane_rotate(we_mask, int'(off), LANES);
  assign rd_unrot    = lane_unrotate(lane_vec_t'(bank_q), int'(rsp_off), LANES);

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [WAW-1:0] a_addr;
    logic           a_we;
    logic [7:0]     a_wdata;

    // Lanes below the start offset hold bytes that spilled into the next word.
    always_comb begin
      if (fill) begin
        a_addr  = ptr;
        a_we    = init_fire;
        a_wdata = bus.init_data[8*b +: 8];
      end else begin
        a_addr  = word + WAW'(OFFW'(b) < off);
        a_we    = acc && !err && (|we_mask_rot[8*b +: 8]);
        a_wdata = wdata_rot[8*b +: 8];
      end
    end

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk     (clk),
      .a_addr  (a_addr),
      .a_we    (a_we),
      .a_wdata (a_wdata),
      .a_rdata (bank_q[8*b +: 8]),
      .b_addr  (ptr + WAW'(1)),
      .b_we    (init_fire && high_en),
      .b_wdata (bus.init_data[8*LANES + 8*b +: 8])
    );
  end

  if (LANES < MAX_LANES) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{rd_unrot[8*MAX_LANES-1:8*LANES],
                         wdata_rot[8*MAX_LANES-1:8*LANES],
                         we_mask_rot[8*MAX_LANES-1:8*LANES]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_off     <= '0;
    end else begin
      rsp_valid_q <= acc;
      rsp_err_q   <= acc && err;
      if (acc) rsp_off <= off;
    end
  end

  // Bank read data is only meaningful in the response cycle of a good access.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q) ? rd_unrot[8*LANES-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      rem          <= '0;
      init_busy_q  <= 1'b0;
      init_done_q  <= 1'b0;
      init_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.init_start) begin
          ptr         <= bus.init_base[AW-1:OFFW];
          rem         <= bus.init_count;
          init_busy_q <= 1'b1;
          if (bus.init_count == 16'd0) begin
            state       <= DONE;
            init_done_q <= 1'b1;
          end else begin
            state        <= FILL;
            init_ready_q <= 1'b1;
          end
        end
        FILL: if (bus.init_valid) begin
          ptr <= ptr + WAW'(2);
          if (rem <= 16'd2) begin
            rem          <= '0;
            state        <= DONE;
            init_ready_q <= 1'b0;
            init_done_q  <= 1'b1;
          end else begin
            rem <= rem - 16'd2;
          end
        end
        DONE: begin
          state       <= IDLE;
          init_busy_q <= 1'b0;
          init_done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.init_busy  = init_busy_q;
  assign bus.init_done  = init_done_q;
  assign bus.init_ready = init_ready_q;

endmodule

// File: doc/dmem_banked.md
# dmem_banked

Parametrised byte-lane data memory for the core's load/store path: `LANES` byte-wide dual-port banks with rotated addressing, so any byte address, aligned or not, is serviced in one access. It adds three things the previous data memory lacked: a valid/ready request interface with a registered, valid-qualified response; out-of-range error reporting; and a sequenced debug-init engine that writes two words per beat through the banks' second ports.

## Interface
- `LANES`, 4, bytes per word; power of 2, ≥2.
- `DEPTH_WORDS`, 1024, words per bank; power of 2. Memory size `MEM_BYTES = LANES*DEPTH_WORDS`.
- `Clk` in 1: clock; all logic rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: access request.
- `req_ready` out 1: request can be accepted.
- `req_addr` in 32: byte address, any alignment.
- `req_we` in `LANES`: byte write enables, bit i = byte i of `req_wdata`; all-zero = read.
- `req_wdata` in `8*LANES`: store data, byte 0 at `req_addr`.
- `rsp_valid` out 1: response valid; no backpressure.
- `rsp_rdata` out `8*LANES`: load data, byte 0 from `req_addr`.
- `rsp_err` out 1: request was out of range.
- `init_start` in 1: start init burst.
- `init_base` in 32: init byte base; low `log2(LANES)` bits ignored.
- `init_count` in 16: number of words to write.
- `init_valid` in 1 / `init_ready` out 1: init beat handshake.
- `init_data` in `16*LANES`: low half = word k, high half = word k+1.
- `init_busy` out 1: init engine active.
- `init_done` out 1: one-cycle completion pulse.

## Operation
- Lane rotation: `off = addr mod LANES`. Byte j of the access lives in bank `(off+j) mod LANES` at word `(addr+j)/LANES`. Read data is un-rotated; write data and enables are rotated the same way.
- Range check: `rsp_err=1` when `addr + LANES - 1 ≥ MEM_BYTES`. An erroring access performs no write and returns `rsp_rdata=0`. Only the low `log2(MEM_BYTES)` address bits index the memory.
- Reads are read-first: an access with both reads and writes returns the pre-write data on all lanes.
- Init FSM states (package enum):
  - IDLE: `req_ready=1`. On `init_start`, the base and count are latched. Count=0 goes to DONE; otherwise FILL.
  - FILL: `req_ready=0`, `init_ready=1`, `init_busy=1`. Each `init_valid` beat writes the low word through port A at `base + 2k*LANES` and the high word through port B at `+LANES`. If only one word remains, the high half is dropped. Init addresses wrap modulo `MEM_BYTES`. After the last word → DONE.
  - DONE: `init_done=1` for one cycle, `init_busy=1`, then → IDLE.
- `init_start` outside IDLE is ignored.
- `init_start` together with an accepted request in IDLE: the request completes normally and the FSM enters FILL (or DONE if count=0) on the next cycle.

## Timing
- A request accepted at edge N gives `rsp_valid`, `rsp_rdata` and `rsp_err` at N+1 for exactly one cycle. Writes are visible to a request accepted at N+1.
- Throughput is 1 request/cycle in IDLE and 2 words/cycle in FILL.
- `req_ready` is combinational from the state only, never from `req_valid`.
- Reset values: `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `init_busy=0`, `init_done=0`, `init_ready=0`, state IDLE, `req_ready=1` from the first cycle after reset.
- Reset mid-FILL returns to IDLE with no `init_done`. Words already written stay; memory contents are never cleared by reset.

## Structure
- Package `dmem_pkg`: `init_state_e` (IDLE/FILL/DONE), lane-rotate and un-rotate functions parameterised by `LANES`.
- Sub-module `dmem_bank`: `DEPTH_WORDS`×8, two write ports, read-first on port A, port B write-only. Instantiated `LANES` times via generate.
- Top module: rotation, range check, response register, init FSM and counter.

## Test plan
- Aligned access: write 0xDEADBEEF at 0x100 with `req_we=4'hF`, then read 0x100 → `rsp_rdata=0xDEADBEEF`, `rsp_err=0`, one cycle after acceptance.
- Unaligned, word-crossing: write 0x11223344 at 0x203, then read 0x200 → 0x44xxxxxx, and read 0x204 → 0xxx112233.
- Partial and read-first: write `req_we=4'b0101`, data 0xAABBCCDD at 0x300 (prior 0) → `rsp_rdata=0`; a read then → 0x00BB00DD.
- Odd init: base 0x40, count 3, beats {0x2,0x1},{junk,0x3} → `init_done` after 2 beats; words 0x40/0x44/0x48 = 1/2/3, 0x4C unchanged.
- Range: read 0xFFD with `MEM_BYTES=4096` → `rsp_err=1`, `rsp_rdata=0`; a write there leaves memory unchanged.
- Reset mid-init: count 8, reset after 2 beats → IDLE, no `init_done`, first 4 words written, `req_ready=1`.
